// File: rtl/cdc_word_synchronizer.sv
// Receiving half of a toggle-handshake word CDC.
// The sender's toggle goes through an N-flop synchronizer. Each detected flip
// captures sending_data, which the sender holds stable until it sees the ack,
// into a 1- or 2-entry output buffer. The buffer is drained over valid/ready.
// The ack toggle is echoed back only once the word has actually been taken,
// so a full buffer naturally stalls the sender.
module cdc_word_synchronizer #(
  parameter int WORD_WIDTH         = 2,
  parameter int EXTRA_CDC_DEPTH    = 1,
  parameter     OUTPUT_BUFFER_TYPE = "SKID"
) (
  input  logic                  receiving_clock,
  input  logic                  receiving_clear,
  input  logic [WORD_WIDTH-1:0] sending_data,
  input  logic                  sending_toggle,
  output logic                  sending_ack_toggle,
  output logic [WORD_WIDTH-1:0] receiving_data,
  output logic                  receiving_valid,
  input  logic                  receiving_ready
);

  localparam int SYNC_DEPTH = 2 + EXTRA_CDC_DEPTH;
  localparam bit IS_HALF    = (OUTPUT_BUFFER_TYPE == "HALF");
  localparam bit IS_SKID    = (OUTPUT_BUFFER_TYPE == "SKID");
  localparam int BUF_DEPTH  = IS_HALF ? 1 : 2;

  // Reject unsupported configurations at elaboration time.
  generate
    if (!IS_HALF && !IS_SKID) begin : g_bad_buffer_type
      $error("cdc_word_synchronizer: OUTPUT_BUFFER_TYPE must be \"HALF\" or \"SKID\"");
    end
    if (WORD_WIDTH < 1) begin : g_bad_width
      $error("cdc_word_synchronizer: WORD_WIDTH must be >= 1");
    end
    if (EXTRA_CDC_DEPTH < 0) begin : g_bad_depth
      $error("cdc_word_synchronizer: EXTRA_CDC_DEPTH must be >= 0");
    end
  endgenerate

  logic [SYNC_DEPTH-1:0]                sync_q;
  logic                                 sync_toggle;
  logic                                 last_toggle_q;
  logic                                 pending;
  logic                                 space;
  logic                                 push;
  logic                                 pop;
  logic [1:0]                           count_q, count_d;
  logic [1:0]                           wr_idx;
  logic [BUF_DEPTH-1:0][WORD_WIDTH-1:0] buf_q, buf_d;

  // Synchronizer chain for the foreign toggle. Only its last stage is used.
  always_ff @(posedge receiving_clock) begin
    if (receiving_clear) sync_q <= '0;
    else                 sync_q <= {sync_q[SYNC_DEPTH-2:0], sending_toggle};
  end

  assign sync_toggle = sync_q[SYNC_DEPTH-1];

  // A word is pending while the synchronized toggle differs from the last one consumed.
  assign pending = sync_toggle ^ last_toggle_q;

  // The head is visible straight from the registers. Valid never looks at ready.
  assign receiving_valid = (count_q != 2'd0);
  assign receiving_data  = buf_q[0];
  assign pop             = receiving_valid & receiving_ready;

  // There is room if the buffer is not full. A full buffer also has room when
  // the head leaves on this same edge.
  assign space = (count_q < 2'(BUF_DEPTH)) | pop;
  assign push  = pending & space;

  // The new word lands behind whatever survives this edge's pop.
  assign wr_idx = count_q - {1'b0, pop};

  // Next buffer contents. A pop shifts entries toward the head. A push then
  // fills the first free slot.
  always_comb begin
    buf_d   = buf_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    if (pop) begin
      for (int i = 0; i < BUF_DEPTH - 1; i++) buf_d[i] = buf_q[i+1];
      buf_d[BUF_DEPTH-1] = '0;
    end
    if (push) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        if (wr_idx == 2'(i)) buf_d[i] = sending_data;
      end
    end
  end

  // Buffer storage and occupancy.
  always_ff @(posedge receiving_clock) begin
    if (receiving_clear) begin
      buf_q   <= '0;
      count_q <= 2'd0;
    end else begin
      buf_q   <= buf_d;
      count_q <= count_d;
    end
  end

  // Record the toggle value of each captured word. This register also drives the ack.
  always_ff @(posedge receiving_clock) begin
    if (receiving_clear) last_toggle_q <= 1'b0;
    else if (push)       last_toggle_q <= sync_toggle;
  end

  assign sending_ack_toggle = last_toggle_q;

endmodule

// File: tb/tb_cdc_word_synchronizer.sv
// Bench for cdc_word_synchronizer. Three instances are used:
// dut_h is HALF with N=3, dut is SKID with N=3, and dut_w is SKID with N=2 and an 8-bit word.
module tb_cdc_word_synchronizer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr;
  // SKID, N=3, 2-bit
  logic       tg, rdy, ack, rvld;
  logic [1:0] dat, rdat;
  // HALF, N=3, 2-bit
  logic       tg_h, rdy_h, ack_h, rvld_h;
  logic [1:0] dat_h, rdat_h;
  // SKID, N=2, 8-bit
  logic       tg_w, rdy_w, ack_w, rvld_w;
  logic [7:0] dat_w, rdat_w;

  cdc_word_synchronizer #(.WORD_WIDTH(2), .EXTRA_CDC_DEPTH(1), .OUTPUT_BUFFER_TYPE("SKID")) dut (
    .receiving_clock(clk), .receiving_clear(clr), .sending_data(dat), .sending_toggle(tg),
    .sending_ack_toggle(ack), .receiving_data(rdat), .receiving_valid(rvld), .receiving_ready(rdy));

  cdc_word_synchronizer #(.WORD_WIDTH(2), .EXTRA_CDC_DEPTH(1), .OUTPUT_BUFFER_TYPE("HALF")) dut_h (
    .receiving_clock(clk), .receiving_clear(clr), .sending_data(dat_h), .sending_toggle(tg_h),
    .sending_ack_toggle(ack_h), .receiving_data(rdat_h), .receiving_valid(rvld_h), .receiving_ready(rdy_h));

  cdc_word_synchronizer #(.WORD_WIDTH(8), .EXTRA_CDC_DEPTH(0), .OUTPUT_BUFFER_TYPE("SKID")) dut_w (
    .receiving_clock(clk), .receiving_clear(clr), .sending_data(dat_w), .sending_toggle(tg_w),
    .sending_ack_toggle(ack_w), .receiving_data(rdat_w), .receiving_valid(rvld_w), .receiving_ready(rdy_w));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // The sender holds its word until the ack matches its toggle, or until the bound runs out.
  task automatic wait_ack(input string nm, input int lim);
    int n;
    n = 0;
    while (ack !== tg && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(nm, ack, tg);
  endtask

  task automatic send(input logic [1:0] w, input string nm);
    @(negedge clk);
    dat = w;
    tg  = ~tg;
    wait_ack(nm, 20);
  endtask

  // One step per clock for dut_h: the inputs applied before an edge and the outputs expected after it.
  typedef struct packed {
    logic       tg;
    logic [1:0] d;
    logic       rdy;
    logic       ev;
    logic [1:0] ed;
    logic       eack;
  } vec_t;

  vec_t tbl[17];

  // Reference for the random run: words are delivered in send order, exactly once each.
  logic [1:0] exp_q[$];
  bit         snd_done;
  localparam int NW = 150;

  initial begin
    int got, cyc, spurious;
    bit prev_stall;
    logic [1:0] prev_data;

    // The first group is a single word with ready held high.
    // The second group is back-pressure: B waits behind A.
    tbl[0]  = '{1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0};
    tbl[1]  = '{1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0};
    tbl[2]  = '{1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0};
    tbl[3]  = '{1'b1, 2'b10, 1'b1, 1'b1, 2'b10, 1'b1};
    tbl[4]  = '{1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b1};
    tbl[5]  = '{1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1};
    tbl[6]  = '{1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1};
    tbl[7]  = '{1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1};
    tbl[8]  = '{1'b0, 2'b01, 1'b0, 1'b1, 2'b01, 1'b0};
    tbl[9]  = '{1'b1, 2'b11, 1'b0, 1'b1, 2'b01, 1'b0};
    tbl[10] = '{1'b1, 2'b11, 1'b0, 1'b1, 2'b01, 1'b0};
    tbl[11] = '{1'b1, 2'b11, 1'b0, 1'b1, 2'b01, 1'b0};
    tbl[12] = '{1'b1, 2'b11, 1'b0, 1'b1, 2'b01, 1'b0};
    tbl[13] = '{1'b1, 2'b11, 1'b0, 1'b1, 2'b01, 1'b0};
    tbl[14] = '{1'b1, 2'b11, 1'b1, 1'b1, 2'b11, 1'b1};
    tbl[15] = '{1'b1, 2'b11, 1'b1, 1'b0, 2'b00, 1'b1};
    tbl[16] = '{1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 1'b1};

    clr = 1'b1;
    tg = 1'b0;   dat = '0;   rdy = 1'b0;
    tg_h = 1'b0; dat_h = '0; rdy_h = 1'b0;
    tg_w = 1'b0; dat_w = '0; rdy_w = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", rvld, 0);     chk("rst_data", rdat, 0);     chk("rst_ack", ack, 0);
    chk("rst_valid_h", rvld_h, 0); chk("rst_data_h", rdat_h, 0); chk("rst_ack_h", ack_h, 0);
    chk("rst_valid_w", rvld_w, 0); chk("rst_data_w", rdat_w, 0); chk("rst_ack_w", ack_w, 0);
    clr = 1'b0;

    // HALF buffer, applied step by step from the table.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      tg_h = tbl[i].tg; dat_h = tbl[i].d; rdy_h = tbl[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_valid", i), rvld_h, tbl[i].ev);
      chk($sformatf("tbl%0d_ack", i), ack_h, tbl[i].eack);
      if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), rdat_h, tbl[i].ed);
    end

    // With N=2 the word is valid after edge 3. The 8-bit word must arrive unchanged.
    @(negedge clk);
    dat_w = 8'hA5; tg_w = 1'b1; rdy_w = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      chk($sformatf("wide_valid_e%0d", e), rvld_w, (e == 3));
      if (e == 3) begin
        chk("wide_data", rdat_w, 8'hA5);
        chk("wide_ack", ack_w, 1);
      end
    end

    // SKID depth test: A and B are buffered and acked. C is left pending with no ack.
    send(2'b01, "skid_ack_a");
    send(2'b10, "skid_ack_b");
    @(negedge clk);
    dat = 2'b11; tg = ~tg;
    repeat (10) @(negedge clk);
    chk("skid_c_no_ack", ack, 0);
    chk("skid_full_valid", rvld, 1);
    chk("skid_head_a", rdat, 2'b01);
    rdy = 1'b1;
    // Consuming A and capturing C happen on the same edge, so the occupancy stays at 2.
    @(negedge clk);
    chk("skid_head_b_valid", rvld, 1);
    chk("skid_head_b", rdat, 2'b10);
    chk("skid_c_acked", ack, 1);
    @(negedge clk);
    chk("skid_head_c_valid", rvld, 1);
    chk("skid_head_c", rdat, 2'b11);
    @(negedge clk);
    chk("skid_drained", rvld, 0);
    rdy = 1'b0;

    // Reset while two words are buffered and a third is still in the synchronizer.
    send(2'b10, "rst_mid_ack_d");
    send(2'b01, "rst_mid_ack_e");
    @(negedge clk);
    dat = 2'b11; tg = ~tg;
    @(negedge clk);
    clr = 1'b1; tg = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    chk("rst_mid_valid", rvld, 0);
    chk("rst_mid_data", rdat, 0);
    chk("rst_mid_ack", ack, 0);
    spurious = 0;
    rdy = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (rvld) spurious++;
    end
    chk("rst_mid_no_spurious", spurious, 0);
    rdy = 1'b0;

    // Random run: random sender gaps, random back-pressure, and a queue scoreboard.
    snd_done = 1'b0;
    exp_q.delete();
    got = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0;
    fork
      begin
        for (int i = 0; i < NW; i++) begin
          logic [1:0] w;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          @(negedge clk);
          w = 2'($urandom);
          dat = w;
          tg = ~tg;
          exp_q.push_back(w);
          wait_ack($sformatf("rnd_ack%0d", i), 100);
        end
        snd_done = 1'b1;
      end
      begin
        while (!(snd_done && exp_q.size() == 0) && cyc < 20000) begin
          @(negedge clk);
          cyc++;
          if (prev_stall) begin
            chk("rnd_hold_valid", rvld, 1);
            chk("rnd_hold_data", rdat, prev_data);
          end
          rdy = ($urandom_range(0, 3) != 0);
          if (rvld && rdy) begin
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL rnd_extra_word actual=%0h required=none", rdat);
            end else begin
              chk("rnd_data", rdat, exp_q.pop_front());
              got++;
            end
          end
          prev_stall = rvld && !rdy;
          prev_data  = rdat;
        end
      end
    join
    chk("rnd_count", got, NW);
    chk("rnd_leftover", exp_q.size(), 0);
    @(negedge clk);
    rdy = 1'b1;
    repeat (6) @(negedge clk);
    chk("rnd_no_dup", rvld, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
